// File: rtl/ppi_pkg.sv
// ppi_pkg: shared definitions for the 8255 PPI bus master.
//   state_t      - bus-cycle FSM states
//   PPI_*        - A1/A0 target encodings
//   DEF_*_CYC    - default phase lengths in clock cycles
//   ppi_max4     - helper used to size the phase timer
package ppi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam logic [1:0] PPI_PORT_A = 2'b00;
  localparam logic [1:0] PPI_PORT_B = 2'b01;
  localparam logic [1:0] PPI_PORT_C = 2'b10;
  localparam logic [1:0] PPI_CTRL   = 2'b11;

  localparam int DEF_SETUP_CYC    = 1;
  localparam int DEF_STROBE_CYC   = 2;
  localparam int DEF_HOLD_CYC     = 1;
  localparam int DEF_RECOVERY_CYC = 1;

  function automatic int ppi_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ppi_bus_master_ppi_phase_timer.sv
// ppi_phase_timer: loadable down-counter shared by all bus-cycle phases.
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load load_val this cycle (takes priority over counting)
//   load_val  - phase length minus one
//   zero      - counter has reached 0 (current phase ends on this edge)
module ppi_phase_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: turns single-cycle host requests into timed 8255 bus cycles.
//   Host side : req, we, addr, wdata in; ready, done, err, rdata out
//   Bus side  : CS, RD, WR, A1, A0, d_out, d_oe out; d_in in
//   clk / Reset (asynchronous, active-high)
// Every bus output is a register; the comb block only computes next values.
// A bus cycle is SETUP -> STROBE -> HOLD -> RECOVER, each phase length set by
// a parameter and timed by one shared down-counter loaded on phase entry.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       A1,
  output logic       A0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  localparam int MAX_CYC = ppi_max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC);
  // Counter holds at most MAX_CYC-1.
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RECOV  = CNT_W'(RECOVERY_CYC - 1);

  state_t           state, state_nxt;
  logic             we_q, we_nxt;
  logic             cs_nxt, rd_nxt, wr_nxt, doe_nxt, ready_nxt, done_nxt, err_nxt;
  logic [1:0]       a_nxt;
  logic [7:0]       dout_nxt, rdata_nxt;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  ppi_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    we_nxt    = we_q;
    cs_nxt    = CS;
    rd_nxt    = RD;
    wr_nxt    = WR;
    a_nxt     = {A1, A0};
    dout_nxt  = d_out;
    doe_nxt   = d_oe;
    rdata_nxt = rdata;
    ready_nxt = ready;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (req && ready) begin
          // Reading the control word is not a legal 8255 access.
          if (!we && addr == PPI_CTRL) begin
            err_nxt = 1'b1;
          end else begin
            we_nxt    = we;
            a_nxt     = addr;
            cs_nxt    = 1'b0;
            ready_nxt = 1'b0;
            state_nxt = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = LD_SETUP;
            if (we) begin
              dout_nxt = wdata;
              doe_nxt  = 1'b1;
            end
          end
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          if (we_q) wr_nxt = 1'b0;
          else      rd_nxt = 1'b0;
          state_nxt = ST_STROBE;
          tmr_load  = 1'b1;
          tmr_val   = LD_STROBE;
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          // Capture on the same edge that raises RD.
          if (!we_q) rdata_nxt = d_in;
          rd_nxt    = 1'b1;
          wr_nxt    = 1'b1;
          state_nxt = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_val   = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          cs_nxt    = 1'b1;
          doe_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_RECOVER;
          tmr_load  = 1'b1;
          tmr_val   = LD_RECOV;
        end
      end
      ST_RECOVER: begin
        if (tmr_zero) begin
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      we_q  <= 1'b0;
      CS    <= 1'b1;
      RD    <= 1'b1;
      WR    <= 1'b1;
      A1    <= 1'b0;
      A0    <= 1'b0;
      d_out <= '0;
      d_oe  <= 1'b0;
      rdata <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      we_q  <= we_nxt;
      CS    <= cs_nxt;
      RD    <= rd_nxt;
      WR    <= wr_nxt;
      {A1, A0} <= a_nxt;
      d_out <= dout_nxt;
      d_oe  <= doe_nxt;
      rdata <= rdata_nxt;
      ready <= ready_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: directed bench for ppi_bus_master (default timing) and
// a second instance with stretched timing (2/3/2/3) sharing the same inputs.
module tb_ppi_bus_master;
  import ppi_pkg::*;

  logic       clk = 1'b0;
  logic       Reset;
  logic       req, we;
  logic [1:0] addr;
  logic [7:0] wdata, d_in;

  logic       ready, done, err, CS, RD, WR, A1, A0, d_oe;
  logic [7:0] rdata, d_out;
  logic       ready2, done2, err2, cs2, rd2, wr2, a1_2, a0_2, doe2;
  logic [7:0] rdata2, dout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppi_bus_master dut (
    .clk(clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata),
    .CS(CS), .RD(RD), .WR(WR), .A1(A1), .A0(A0),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );

  ppi_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .RECOVERY_CYC(3)) dut2 (
    .clk(clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready2), .done(done2), .err(err2), .rdata(rdata2),
    .CS(cs2), .RD(rd2), .WR(wr2), .A1(a1_2), .A0(a0_2),
    .d_out(dout2), .d_oe(doe2), .d_in(d_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus invariants on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    chk("rd_wr_excl", {31'd0, (!RD && !WR)}, 32'd0);
    chk("strobe_cs", {31'd0, ((!RD || !WR) && CS)}, 32'd0);
    chk("rd_wr_excl2", {31'd0, (!rd2 && !wr2)}, 32'd0);
    chk("strobe_cs2", {31'd0, ((!rd2 || !wr2) && cs2)}, 32'd0);
  end

  // One default-timing bus cycle; k is the number of edges after accept.
  task automatic run_bus(input string tag, input logic w, input logic [1:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rdata);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk({tag, "_cs"},    CS,    (k <= 3) ? 1'b0 : 1'b1);
      chk({tag, "_rd"},    RD,    (!w && k >= 1 && k <= 2) ? 1'b0 : 1'b1);
      chk({tag, "_wr"},    WR,    (w && k >= 1 && k <= 2) ? 1'b0 : 1'b1);
      chk({tag, "_doe"},   d_oe,  (w && k <= 3) ? 1'b1 : 1'b0);
      chk({tag, "_done"},  done,  (k == 4) ? 1'b1 : 1'b0);
      chk({tag, "_ready"}, ready, (k == 5) ? 1'b1 : 1'b0);
      if (k <= 3) chk({tag, "_addr"}, {A1, A0}, a);
      if (w && k <= 3) chk({tag, "_dout"}, d_out, d);
      if (k == 4) chk({tag, "_rdata"}, rdata, exp_rdata);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   falls, dones, gap, min_gap;
    logic prev_cs;
    logic [7:0] cap [2];

    Reset = 1'b1; req = 1'b0; we = 1'b0; addr = 2'b00; wdata = 8'h00; d_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", CS, 1'b1);
    chk("rst_rd", RD, 1'b1);
    chk("rst_wr", WR, 1'b1);
    chk("rst_addr", {A1, A0}, 2'b00);
    chk("rst_dout", d_out, 8'h00);
    chk("rst_doe", d_oe, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", ready, 1'b1);
    Reset = 1'b0;
    tick();

    // Write to port A, then read port B.
    run_bus("wr_a", 1'b1, PPI_PORT_A, 8'hA5, 8'h00);
    d_in = 8'h3C;
    run_bus("rd_b", 1'b0, PPI_PORT_B, 8'h00, 8'h3C);
    d_in = 8'hFF;

    // Control-word read is rejected.
    req = 1'b1; we = 1'b0; addr = PPI_CTRL;
    tick();
    req = 1'b0;
    chk("ctrl_rd_err", err, 1'b1);
    chk("ctrl_rd_cs", CS, 1'b1);
    chk("ctrl_rd_ready", ready, 1'b1);
    chk("ctrl_rd_done", done, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ctrl_rd_err_end", err, 1'b0);
      chk("ctrl_rd_quiet", {CS, RD, WR, done}, 4'b1110);
    end

    // Control-word write is a normal write; rdata keeps the last read.
    run_bus("wr_ctl", 1'b1, PPI_CTRL, 8'h80, 8'h3C);
    chk("ctrl_wr_rdata", rdata, 8'h3C);

    // Back-to-back: req held high for 12 cycles, data changes every cycle.
    falls = 0; dones = 0; gap = 0; min_gap = 99; prev_cs = CS;
    for (int i = 0; i < 14; i++) begin
      req = (i < 12); we = 1'b1; addr = PPI_PORT_C; wdata = 8'(i + 1);
      tick();
      if (prev_cs && !CS) begin
        if (falls < 2) cap[falls] = d_out;
        if (falls > 0 && gap < min_gap) min_gap = gap;
        falls++;
      end
      gap = CS ? gap + 1 : 0;
      if (done) dones++;
      prev_cs = CS;
    end
    req = 1'b0;
    chk("b2b_cycles", falls, 2);
    chk("b2b_dones", dones, 2);
    chk("b2b_data0", cap[0], 8'h01);
    chk("b2b_data1", cap[1], 8'h07);
    chk("b2b_gap", {31'd0, (min_gap >= 1)}, 32'd1);
    repeat (3) tick();

    // A req pulse while busy is ignored.
    falls = 0; dones = 0; prev_cs = CS;
    for (int i = 0; i < 12; i++) begin
      req = (i == 0 || i == 2); we = 1'b1; addr = PPI_PORT_A; wdata = 8'h5A;
      tick();
      if (prev_cs && !CS) falls++;
      if (done) dones++;
      prev_cs = CS;
    end
    req = 1'b0;
    chk("busy_req_cycles", falls, 1);
    chk("busy_req_dones", dones, 1);

    // Asynchronous reset while WR is low.
    req = 1'b1; we = 1'b1; addr = PPI_PORT_B; wdata = 8'hC3;
    tick();
    req = 1'b0;
    tick();
    chk("mid_pre_wr", WR, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_cs", CS, 1'b1);
    chk("mid_rst_wr", WR, 1'b1);
    chk("mid_rst_doe", d_oe, 1'b0);
    chk("mid_rst_ready", ready, 1'b1);
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_no_done", done, 1'b0);
      chk("mid_idle_cs", CS, 1'b1);
    end
    chk("mid_rdata_cleared", rdata, 8'h00);
    d_in = 8'h5A;
    run_bus("rd_after_rst", 1'b0, PPI_PORT_C, 8'h00, 8'h5A);

    // Stretched-timing instance: setup 2, strobe 3, hold 2, recovery 3.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    req = 1'b1; we = 1'b1; addr = PPI_PORT_B; wdata = 8'h96;
    tick();
    req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("sw_cs", cs2, (k <= 6) ? 1'b0 : 1'b1);
      chk("sw_wr", wr2, (k >= 2 && k <= 4) ? 1'b0 : 1'b1);
      chk("sw_done", done2, (k == 7) ? 1'b1 : 1'b0);
      chk("sw_ready", ready2, (k >= 10) ? 1'b1 : 1'b0);
      if (k <= 6) chk("sw_dout", dout2, 8'h96);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
